// File: rtl/lfsr_stream_checker_pkg.sv
// Shared rng constants: LFSR width, taps and generator seed.
// Both generator and checker import these to stay consistent.
package lfsr_stream_checker_pkg;

  localparam int LFSR_W = 43;

  localparam int TAP_A = 42;
  localparam int TAP_B = 40;
  localparam int TAP_C = 19;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] LFSR_SEED =
    43'h400_0000_0000;

  typedef enum logic {
    SEED = 1'b0,
    LOCK = 1'b1
  } chk_state_e;

  function automatic logic lfsr_fb(
    input logic [LFSR_W-1:0] s
  );
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

endpackage

// File: rtl/lfsr_stream_checker_if.sv
// Stream input and status bundle of the rng checker.
// master drives the stream, slave is the checker.
interface lfsr_stream_checker_if #(
  parameter int CNT_W = 32
);

  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic             sticky_err;
  logic             zero_seed;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_bit, clear,
    input  in_ready, locked, err_pulse,
    input  sticky_err, zero_seed,
    input  bit_count, err_count
  );

  modport slave (
    input  in_valid, in_bit, clear,
    output in_ready, locked, err_pulse,
    output sticky_err, zero_seed,
    output bit_count, err_count
  );

endinterface

// File: rtl/lfsr_stream_checker_predict.sv
// Combinational tap XOR of the 43-bit rng window.
// Gives the next stream bit from the last 43 bits.
module lfsr_predict
  import lfsr_stream_checker_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  output logic              pred
);

  assign pred = lfsr_fb(state);

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 43-bit rng bit stream.
// Seeds from 43 bits, then predicts and counts mismatches.
module lfsr_stream_checker
  import lfsr_stream_checker_pkg::*;
#(
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  lfsr_stream_checker_if.slave bus
);

  localparam logic [5:0] SEED_LAST =
    6'(LFSR_W - 1);
  localparam logic [3:0] MISS_LAST =
    4'(ERR_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e        state;
  logic [LFSR_W-1:0] hist;
  logic [LFSR_W-1:0] hist_nxt;
  logic [5:0]        scnt;
  logic [3:0]        mcnt;
  logic              pred;
  logic              miss;
  logic              ready_q;
  logic              pulse_q;
  logic              sticky_q;
  logic              zero_q;
  logic [CNT_W-1:0]  bit_q;
  logic [CNT_W-1:0]  err_q;

  assign hist_nxt = {bus.in_bit, hist[LFSR_W-1:1]};
  assign miss     = bus.in_bit ^ pred;

  lfsr_predict u_pred (
    .state (hist),
    .pred  (pred)
  );

  // Seed/lock FSM, history shift, counters and flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= SEED;
      hist     <= '0;
      scnt     <= '0;
      mcnt     <= '0;
      ready_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      bit_q    <= '0;
      err_q    <= '0;
    end else begin
      ready_q <= 1'b1;
      pulse_q <= 1'b0;
      if (bus.in_valid) begin
        hist <= hist_nxt;
        unique case (state)
          SEED: begin
            if (scnt == SEED_LAST) begin
              scnt <= '0;
              if (hist_nxt != '0) begin
                state  <= LOCK;
                zero_q <= 1'b0;
              end else begin
                zero_q <= 1'b1;
              end
            end else begin
              scnt <= scnt + 6'd1;
            end
          end
          LOCK: begin
            if (bit_q != CNT_MAX)
              bit_q <= bit_q + CNT_ONE;
            if (miss) begin
              pulse_q  <= 1'b1;
              sticky_q <= 1'b1;
              if (err_q != CNT_MAX)
                err_q <= err_q + CNT_ONE;
              if (mcnt == MISS_LAST) begin
                state <= SEED;
                scnt  <= '0;
                mcnt  <= '0;
              end else begin
                mcnt <= mcnt + 4'd1;
              end
            end else begin
              mcnt <= '0;
            end
          end
          default: state <= SEED;
        endcase
      end
      if (bus.clear) begin
        bit_q    <= '0;
        err_q    <= '0;
        sticky_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.locked     = (state == LOCK);
  assign bus.err_pulse  = pulse_q;
  assign bus.sticky_err = sticky_q;
  assign bus.zero_seed  = zero_q;
  assign bus.bit_count  = bit_q;
  assign bus.err_count  = err_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Self-checking bench for lfsr_stream_checker.
// Random stimulus against a behavioural stream model.
module tb_lfsr_stream_checker;

  localparam logic [42:0] GSEED = 43'h400_0000_0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lfsr_stream_checker_if #(.CNT_W(32)) bus ();
  lfsr_stream_checker_if #(.CNT_W(4))  bus4 ();

  assign bus4.in_valid = bus.in_valid;
  assign bus4.in_bit   = bus.in_bit;
  assign bus4.clear    = bus.clear;

  lfsr_stream_checker #(.ERR_LIMIT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  lfsr_stream_checker #(.ERR_LIMIT(4), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  int errors = 0;
  int checks = 0;

  // behavioural checker model
  bit q[$];
  int m_locked, m_scnt, m_streak, m_zero, m_sticky;
  int m_bitc, m_errc, m_pulses;
  int pulses, idle_pulses;

  // generator: bits sent since restart
  bit gb[$];

  task automatic model_reset();
    q.delete();
    m_locked = 0; m_scnt = 0; m_streak = 0;
    m_zero = 0; m_sticky = 0;
    m_bitc = 0; m_errc = 0; m_pulses = 0;
    pulses = 0; idle_pulses = 0;
    gb.delete();
  endtask

  task automatic model_bit(input bit b);
    bit p;
    bit allz;
    if (m_locked == 0) begin
      q.push_back(b);
      if (q.size() > 43) void'(q.pop_front());
      m_scnt++;
      if (m_scnt == 43) begin
        m_scnt = 0;
        allz = 1;
        foreach (q[i]) if (q[i]) allz = 0;
        if (allz) m_zero = 1;
        else begin
          m_locked = 1;
          m_zero = 0;
        end
      end
    end else begin
      p = q[42] ^ q[40] ^ q[19] ^ q[0];
      m_bitc++;
      if (b != p) begin
        m_errc++;
        m_sticky = 1;
        m_pulses++;
        m_streak++;
        if (m_streak == 4) begin
          m_locked = 0;
          m_streak = 0;
          m_scnt = 0;
        end
      end else m_streak = 0;
      q.push_back(b);
      if (q.size() > 43) void'(q.pop_front());
    end
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.clear    = c;
    @(posedge clk);
    #1;
    if (bus.err_pulse === 1'b1) begin
      pulses++;
      if (!v) idle_pulses++;
    end
    if (v) model_bit(b);
    if (c) begin
      m_bitc = 0;
      m_errc = 0;
      m_sticky = 0;
    end
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  task automatic gen_bit(input bit flip, output bit b);
    int n;
    bit g;
    n = gb.size();
    if (n < 43) g = GSEED[n];
    else g = gb[n-1] ^ gb[n-3] ^ gb[n-24] ^ gb[n-43];
    b = g ^ flip;
    gb.push_back(b);
  endtask

  task automatic send(input bit flip);
    bit b;
    gen_bit(flip, b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.clear = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: got %b want 0", bus.in_ready);
    end
    checks++;
    if ({bus.locked, bus.err_pulse, bus.sticky_err,
         bus.zero_seed} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_flags: got %b want 0000",
        {bus.locked, bus.err_pulse, bus.sticky_err,
         bus.zero_seed});
    end
    checks++;
    if (bus.bit_count !== 32'd0 || bus.err_count !== 32'd0)
    begin
      errors++;
      $display("FAIL rst_counts: got %0d/%0d want 0/0",
        bus.bit_count, bus.err_count);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_up: got %b want 1", bus.in_ready);
    end
    // partial seed then mid-stream reset
    repeat (20) send(1'b0);
    apply_reset();
    for (int i = 0; i < 43; i++) begin
      send(1'b0);
      if (i == 41) begin
        checks++;
        if (bus.locked !== 1'b0) begin
          errors++;
          $display("FAIL partial_discard: got %b want 0",
            bus.locked);
        end
      end
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL relock_after_rst: got %b want 1",
        bus.locked);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      send(1'b0);
      if (i == 41 || i == 42) begin
        checks++;
        if (bus.locked !== (i == 42)) begin
          errors++;
          $display("FAIL lock_edge bit %0d: got %b want %b",
            i, bus.locked, (i == 42));
        end
      end
    end
    checks++;
    if (bus.bit_count !== 32'd957 || m_bitc != 957) begin
      errors++;
      $display("FAIL lock_bits: got %0d want 957",
        bus.bit_count);
    end
    checks++;
    if (bus.err_count !== 32'd0 || bus.sticky_err !== 1'b0
        || pulses != 0) begin
      errors++;
      $display("FAIL lock_errs: got %0d/%b/%0d want 0/0/0",
        bus.err_count, bus.sticky_err, pulses);
    end
    checks++;
    if (bus4.bit_count !== 4'hf) begin
      errors++;
      $display("FAIL sat_bits: got %0d want 15",
        bus4.bit_count);
    end
  endtask

  task automatic test_single_err();
    apply_reset();
    for (int i = 0; i < 1000; i++) send(i == 200);
    checks++;
    if (pulses != 1 || bus.err_count !== 32'd1) begin
      errors++;
      $display("FAIL single_err: got %0d/%0d want 1/1",
        pulses, bus.err_count);
    end
    checks++;
    if (bus.sticky_err !== 1'b1 || bus.locked !== 1'b1)
    begin
      errors++;
      $display("FAIL single_flags: got %b%b want 11",
        bus.sticky_err, bus.locked);
    end
    checks++;
    if (bus.bit_count !== 32'(m_bitc) || m_bitc != 957)
    begin
      errors++;
      $display("FAIL single_bits: got %0d want 957",
        bus.bit_count);
    end
  endtask

  task automatic test_burst();
    apply_reset();
    repeat (100) send(1'b0);
    for (int k = 0; k < 4; k++) begin
      send(1'b1);
      checks++;
      if (bus.locked !== (k < 3)) begin
        errors++;
        $display("FAIL burst_lock k=%0d: got %b want %b",
          k, bus.locked, (k < 3));
      end
    end
    checks++;
    if (bus.err_count !== 32'd4 || bus4.err_count !== 4'd4)
    begin
      errors++;
      $display("FAIL burst_errs: got %0d want 4",
        bus.err_count);
    end
    for (int i = 0; i < 43; i++) begin
      send(1'b0);
      if (i == 41 || i == 42) begin
        checks++;
        if (bus.locked !== (i == 42)) begin
          errors++;
          $display("FAIL burst_relock %0d: got %b want %b",
            i, bus.locked, (i == 42));
        end
      end
    end
    repeat (50) send(1'b0);
    checks++;
    if (bus.bit_count !== 32'd111 || m_bitc != 111
        || bus.err_count !== 32'(m_errc)) begin
      errors++;
      $display("FAIL burst_final: got %0d/%0d want 111/%0d",
        bus.bit_count, bus.err_count, m_errc);
    end
  endtask

  task automatic test_zero_seed();
    apply_reset();
    repeat (43) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.zero_seed !== 1'b1 || bus.locked !== 1'b0)
    begin
      errors++;
      $display("FAIL zero_seed: got z%b l%b want z1 l0",
        bus.zero_seed, bus.locked);
    end
    gb.delete();
    repeat (42) send(1'b0);
    checks++;
    if (bus.zero_seed !== 1'b1 || bus.locked !== 1'b0)
    begin
      errors++;
      $display("FAIL zero_hold: got z%b l%b want z1 l0",
        bus.zero_seed, bus.locked);
    end
    send(1'b0);
    checks++;
    if (bus.zero_seed !== 1'b0 || bus.locked !== 1'b1)
    begin
      errors++;
      $display("FAIL zero_relock: got z%b l%b want z0 l1",
        bus.zero_seed, bus.locked);
    end
    repeat (20) send(1'b0);
    checks++;
    if (bus.err_count !== 32'd0
        || bus.bit_count !== 32'(m_bitc)) begin
      errors++;
      $display("FAIL zero_after: got %0d/%0d want 0/%0d",
        bus.err_count, bus.bit_count, m_bitc);
    end
  endtask

  task automatic test_gaps();
    int sent;
    int cyc;
    apply_reset();
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      cyc++;
      if ($urandom_range(1, 0) == 1) begin
        send(sent == 500);
        sent++;
      end else begin
        step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      end
    end
    checks++;
    if (sent != 1000) begin
      errors++;
      $display("FAIL gaps_budget: got %0d want 1000", sent);
    end
    checks++;
    if (idle_pulses != 0) begin
      errors++;
      $display("FAIL gaps_idle_pulse: got %0d want 0",
        idle_pulses);
    end
    checks++;
    if (bus.bit_count !== 32'd957
        || bus.err_count !== 32'(m_errc) || m_errc != 1
        || pulses != m_pulses) begin
      errors++;
      $display("FAIL gaps_counts: got %0d/%0d/%0d want 957/1/%0d",
        bus.bit_count, bus.err_count, pulses, m_pulses);
    end
  endtask

  task automatic test_clear();
    bit b;
    apply_reset();
    repeat (100) send(1'b0);
    for (int k = 0; k < 3; k++) begin
      send(1'b1);
      repeat (5) send(1'b0);
    end
    checks++;
    if (bus.err_count !== 32'd3 || m_errc != 3
        || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_clear: got %0d l%b want 3 l1",
        bus.err_count, bus.locked);
    end
    gen_bit(1'b0, b);
    step(1'b1, b, 1'b1);
    checks++;
    if (bus.err_count !== 32'd0 || bus.bit_count !== 32'd0
        || bus.sticky_err !== 1'b0) begin
      errors++;
      $display("FAIL clear: got %0d/%0d/%b want 0/0/0",
        bus.err_count, bus.bit_count, bus.sticky_err);
    end
    checks++;
    if (bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL clear_lock: got %b want 1", bus.locked);
    end
    send(1'b0);
    checks++;
    if (bus.bit_count !== 32'(m_bitc) || m_bitc != 1) begin
      errors++;
      $display("FAIL post_clear: got %0d want 1",
        bus.bit_count);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.locked, bus.err_pulse,
         bus.sticky_err, bus.zero_seed} !== 5'b0
        || bus.bit_count !== 32'd0
        || bus.err_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_all: got %b %0d %0d want 0 0 0",
        {bus.in_ready, bus.locked, bus.err_pulse,
         bus.sticky_err, bus.zero_seed},
        bus.bit_count, bus.err_count);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.clear = 1'b0;
    model_reset();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.clear = 1'b0;
    model_reset();
    test_reset();
    test_lock();
    test_single_err();
    test_burst();
    test_zero_seed();
    test_gaps();
    test_clear();
    $display("Result: errors=%0d of %0d checks",
      errors, checks);
    $finish;
  end

endmodule
